// File: rtl/mem_arb_pkg.sv
// Shared types for the block-RAM port arbiter: request record and
// read-response tag carried through the latency pipeline.
package mem_arb_pkg;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 32;
  localparam int unsigned TAG_ID_W   = 3;

  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

  // Wide enough for the largest supported requester count (8).
  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
  } rsp_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo NUM_REQ. The pointer register lives in the caller.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_any
);

  always_comb begin
    logic [ID_W-1:0] idx;
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((32'(ptr) + k) % NUM_REQ);
      if (!gnt_any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = idx;
        gnt_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one block-RAM port among NUM_REQ requesters: round-robin grant,
// registered single-beat issue, and read-response routing by tag pipeline.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32
) (
  input  logic                           clock,
  input  logic                           rst,
  input  logic                           arb_en,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_W-1:0]              rsp_rdata,
  output logic                           mem_en,
  output logic                           mem_we,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_din,
  input  logic [DATA_W-1:0]              mem_dout
);

  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic               mem_en_q, mem_en_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_din_q, mem_din_d;
  logic [ID_W-1:0]    issue_id_q, issue_id_d;
  rsp_tag_t [READ_LATENCY-1:0] tag_q, tag_d;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_any;
  logic               grant;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  assign grant     = arb_en && !rst && gnt_any;
  assign req_ready = grant ? gnt : '0;

  always_comb begin
    ptr_d      = ptr_q;
    mem_en_d   = 1'b0;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    issue_id_d = issue_id_q;
    if (grant) begin
      mem_en_d   = 1'b1;
      mem_we_d   = req_we[gnt_id];
      mem_addr_d = req_addr[gnt_id];
      mem_din_d  = req_wdata[gnt_id];
      issue_id_d = gnt_id;
      ptr_d      = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // Stage 0 captures the access presented to the RAM this cycle, so the
  // tail lines up with mem_dout READ_LATENCY cycles after mem_en.
  always_comb begin
    tag_d        = tag_q;
    tag_d[0].vld = mem_en_q && !mem_we_q;
    tag_d[0].id  = TAG_ID_W'(issue_id_q);
    for (int unsigned k = 1; k < READ_LATENCY; k++) begin
      tag_d[k] = tag_q[k-1];
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      ptr_q      <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      issue_id_q <= '0;
      tag_q      <= '0;
    end else begin
      ptr_q      <= ptr_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      issue_id_q <= issue_id_d;
      tag_q      <= tag_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    if (tag_q[READ_LATENCY-1].vld) begin
      rsp_rdata = mem_dout;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (tag_q[READ_LATENCY-1].id == TAG_ID_W'(i)) rsp_valid[i] = 1'b1;
      end
    end
  end

  assign mem_en   = mem_en_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 2-cycle-latency RAM model.
module tb_mem_port_arbiter;

  logic             clock = 1'b0;
  logic             rst;
  logic             arb_en;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_we;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0]       rsp_valid;
  logic [31:0]      rsp_rdata;
  logic             mem_en;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_din;
  logic [31:0]      mem_dout;

  int unsigned tests = 0;
  int unsigned fails = 0;

  mem_port_arbiter #(
    .NUM_REQ      (2),
    .READ_LATENCY (2),
    .ADDR_W       (32),
    .DATA_W       (32)
  ) dut (
    .clock     (clock),
    .rst       (rst),
    .arb_en    (arb_en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  always #5 clock = ~clock;

  // RAM model: read data appears two cycles after the mem_en cycle.
  logic [31:0] ram [0:255];
  logic [31:0] rd_p1;
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_din;
      else        rd_p1 <= ram[mem_addr[7:0]];
    end
    mem_dout <= rd_p1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[8'h20] = 32'hDEADBEEF;
    ram[8'h04] = 32'h44444444;
    ram[8'h08] = 32'h88888888;
    rd_p1 = '0;
    mem_dout = '0;

    // Reset: no grant even with requests pending
    rst = 1'b1; arb_en = 1'b1; req_valid = 2'b11; req_we = 2'b00;
    req_addr = '0; req_wdata = '0;
    @(negedge clock); #1;
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_din", mem_din, 32'h0);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);

    // 1. Single read from R0
    @(negedge clock); rst = 1'b0; req_valid = 2'b01; req_addr[0] = 32'h20; #1;
    chk("t1_ready", req_ready, 2'b01);
    @(negedge clock); req_valid = 2'b00; #1;
    chk("t1_mem_en", mem_en, 1'b1);
    chk("t1_mem_we", mem_we, 1'b0);
    chk("t1_mem_addr", mem_addr, 32'h20);
    chk("t1_rsp_early1", rsp_valid, 2'b00);
    @(negedge clock); #1;
    chk("t1_rsp_early2", rsp_valid, 2'b00);
    chk("t1_mem_en_off", mem_en, 1'b0);
    @(negedge clock); #1;
    chk("t1_rsp_valid", rsp_valid, 2'b01);
    chk("t1_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    @(negedge clock); #1;
    chk("t1_rsp_done", rsp_valid, 2'b00);
    chk("t1_rdata_zero", rsp_rdata, 32'h0);

    // Re-reset so the contention pattern starts from ptr=0
    rst = 1'b1;
    @(negedge clock); rst = 1'b0;

    // 2+4. Contention, both reading; responses in issue order
    req_addr[0] = 32'h4; req_addr[1] = 32'h8; req_we = 2'b00;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clock);
      req_valid = (i < 6) ? 2'b11 : 2'b00;
      #1;
      if (i < 6) chk($sformatf("t2_grant%0d", i), req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i >= 1 && i <= 6) chk($sformatf("t2_mem_en%0d", i), mem_en, 1'b1);
      if (i >= 1 && i <= 6)
        chk($sformatf("t2_mem_addr%0d", i), mem_addr, (i % 2 == 1) ? 32'h4 : 32'h8);
      if (i >= 3 && i <= 8) begin
        chk($sformatf("t4_rsp_id%0d", i), rsp_valid, ((i - 3) % 2 == 0) ? 2'b01 : 2'b10);
        chk($sformatf("t4_rsp_data%0d", i), rsp_rdata,
            ((i - 3) % 2 == 0) ? 32'h44444444 : 32'h88888888);
      end
      if (i == 9) chk("t2_rsp_idle", rsp_valid, 2'b00);
    end

    // 3. R1 write then read of the same address, back to back
    @(negedge clock); req_valid = 2'b10; req_we = 2'b10;
    req_addr[1] = 32'h10; req_wdata[1] = 32'h55; #1;
    chk("t3_wr_ready", req_ready, 2'b10);
    @(negedge clock); req_we = 2'b00; #1;
    chk("t3_rd_ready", req_ready, 2'b10);
    chk("t3_wr_mem_en", mem_en, 1'b1);
    chk("t3_wr_mem_we", mem_we, 1'b1);
    chk("t3_wr_addr", mem_addr, 32'h10);
    chk("t3_wr_din", mem_din, 32'h55);
    @(negedge clock); req_valid = 2'b00; #1;
    chk("t3_rd_mem_en", mem_en, 1'b1);
    chk("t3_rd_mem_we", mem_we, 1'b0);
    chk("t3_rsp_c", rsp_valid, 2'b00);
    @(negedge clock); #1;
    chk("t3_no_wr_rsp", rsp_valid, 2'b00);
    @(negedge clock); #1;
    chk("t3_rsp_valid", rsp_valid, 2'b10);
    chk("t3_rsp_data", rsp_rdata, 32'h55);

    // 5. Freeze with a read in flight (ptr is 0 here)
    @(negedge clock); req_valid = 2'b01; req_addr[0] = 32'h20; #1;
    chk("t5_ready", req_ready, 2'b01);
    @(negedge clock); arb_en = 1'b0; req_valid = 2'b11; #1;
    chk("t5_frz_ready1", req_ready, 2'b00);
    chk("t5_issue", mem_en, 1'b1);
    @(negedge clock); #1;
    chk("t5_frz_ready2", req_ready, 2'b00);
    chk("t5_no_mem_en1", mem_en, 1'b0);
    @(negedge clock); #1;
    chk("t5_no_mem_en2", mem_en, 1'b0);
    chk("t5_rsp_valid", rsp_valid, 2'b01);
    chk("t5_rsp_data", rsp_rdata, 32'hDEADBEEF);
    @(negedge clock); arb_en = 1'b1; req_addr[1] = 32'h8; #1;
    chk("t5_resume_ptr", req_ready, 2'b10);

    // 6. Reset one cycle after a read accept
    @(negedge clock); req_valid = 2'b01; req_addr[0] = 32'h4; #1;
    chk("t6_ready", req_ready, 2'b01);
    @(negedge clock); req_valid = 2'b00; rst = 1'b1; #1;
    chk("t6_rst_ready", req_ready, 2'b00);
    chk("t6_issue", mem_en, 1'b1);
    @(negedge clock); rst = 1'b0; #1;
    chk("t6_mem_en_clr", mem_en, 1'b0);
    chk("t6_rsp_a", rsp_valid, 2'b00);
    @(negedge clock); #1;
    chk("t6_rsp_b", rsp_valid, 2'b00);
    chk("t6_rdata_b", rsp_rdata, 32'h0);
    @(negedge clock); req_valid = 2'b11; #1;
    chk("t6_ptr_reset", req_ready, 2'b01);
    @(negedge clock); req_valid = 2'b00;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
